// File: rtl/progress_sched.sv
// progress_sched: shares one progress-bar overlay between N loaders, with a hold on completion.
// Define PROGRESS_ROTATE_EN to time-share the bar between simultaneous loads.
module progress_sched #(
    parameter int N            = 4,
    parameter int DWELL_FRAMES = 50,
    parameter int HOLD_FRAMES  = 25
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            vblank,
    input  logic [N-1:0]    src_active,
    input  logic [25*N-1:0] src_current,
    input  logic [25*N-1:0] src_max,
    output logic            enable,
    output logic [24:0]     current,
    output logic [24:0]     max,
    output logic [2:0]      sel,
    output logic            busy
);

`ifdef PROGRESS_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    localparam logic [7:0] DWELL = 8'(DWELL_FRAMES);
    localparam logic [7:0] HOLD  = 8'(HOLD_FRAMES);

    typedef enum logic [1:0] {IDLE, SHOW, HOLD_ST} state_t;

    state_t      state_q, state_d;
    logic        vblank_q;
    logic        tick;
    logic [7:0]  fcnt_q, fcnt_d, fcnt_inc;
    logic [2:0]  sel_q, sel_d, nxt;
    logic [24:0] cur_q, cur_d, max_q, max_d;
    logic [7:0]  act8;
    logic        live, other, any;

    // Scan order: round-robin from sel+1 when rotating, else lowest index wins
    function automatic logic [2:0] pick(input logic [7:0] act, input logic [2:0] from);
        logic [2:0] r;
        int idx;
        r = from;
        for (int k = N; k >= 1; k--) begin
            idx = ROT ? (int'(from) + k) % N : k - 1;
            if (act[3'(idx)]) r = 3'(idx);
        end
        return r;
    endfunction

    // The overlay steps by max[24:7]; a tiny max would stall it
    function automatic logic [49:0] clean(input logic [24:0] c, input logic [24:0] m);
        if (m < 25'd128) return {25'd0, 25'd128};
        return {(c > m) ? m : c, m};
    endfunction

    assign tick     = vblank & ~vblank_q;
    assign act8     = 8'(src_active);
    assign live     = act8[sel_q];
    assign other    = |(act8 & ~(8'd1 << sel_q));
    assign any      = |src_active;
    assign nxt      = pick(act8, sel_q);
    assign fcnt_inc = fcnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        sel_d   = sel_q;
        cur_d   = cur_q;
        max_d   = max_q;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    sel_d   = nxt;
                    fcnt_d  = 8'd0;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (!live) begin
                    cur_d   = max_q;
                    fcnt_d  = 8'd0;
                    state_d = HOLD_ST;
                    if (HOLD == 8'd0) begin
                        if (any) begin
                            sel_d   = nxt;
                            state_d = SHOW;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else if (ROT && fcnt_q == DWELL && other) begin
                    sel_d  = nxt;
                    fcnt_d = 8'd0;
                end else if (ROT && tick && fcnt_q != DWELL) begin
                    fcnt_d = fcnt_inc;
                end
            end
            HOLD_ST: begin
                if (live) begin
                    fcnt_d  = 8'd0;
                    state_d = SHOW;
                end else if (tick) begin
                    if (fcnt_inc == HOLD) begin
                        fcnt_d = 8'd0;
                        if (any) begin
                            sel_d   = nxt;
                            state_d = SHOW;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        fcnt_d = fcnt_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == SHOW)
            {cur_d, max_d} = clean(src_current[25*int'(sel_d) +: 25],
                                   src_max[25*int'(sel_d) +: 25]);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            vblank_q <= 1'b0;
            fcnt_q   <= 8'd0;
            sel_q    <= 3'd0;
            cur_q    <= 25'd0;
            max_q    <= 25'd0;
        end else begin
            state_q  <= state_d;
            vblank_q <= vblank;
            fcnt_q   <= fcnt_d;
            sel_q    <= sel_d;
            cur_q    <= cur_d;
            max_q    <= max_d;
        end
    end

    assign enable  = (state_q != IDLE);
    assign busy    = (state_q != IDLE);
    assign current = cur_q;
    assign max     = max_q;
    assign sel     = sel_q;

endmodule

// File: tb/tb_progress_sched.sv
// Directed bench for progress_sched (N=4, DWELL_FRAMES=3, HOLD_FRAMES=25).
module tb_progress_sched;

`ifdef PROGRESS_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         vblank = 1'b0;
    logic [3:0]   src_active = '0;
    logic [99:0]  src_current = '0;
    logic [99:0]  src_max = '0;
    logic         enable;
    logic [24:0]  current;
    logic [24:0]  max;
    logic [2:0]   sel;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    progress_sched #(.N(4), .DWELL_FRAMES(3), .HOLD_FRAMES(25)) dut (
        .clk(clk), .reset_n(reset_n), .vblank(vblank),
        .src_active(src_active), .src_current(src_current), .src_max(src_max),
        .enable(enable), .current(current), .max(max), .sel(sel), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  act;
        logic [24:0] c0, m0;
        logic        en;
        logic [2:0]  sel;
        logic [24:0] cur, mx;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        step();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic set_src(input int i, input logic [24:0] c, input logic [24:0] m);
        src_current[25*i +: 25] = c;
        src_max[25*i +: 25] = m;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic en, input logic [2:0] s,
                           input logic [24:0] c, input logic [24:0] m);
        chk({tag, ".enable"}, 32'(enable), 32'(en));
        chk({tag, ".busy"}, 32'(busy), 32'(en));
        chk({tag, ".sel"}, 32'(sel), 32'(s));
        chk({tag, ".current"}, 32'(current), 32'(c));
        chk({tag, ".max"}, 32'(max), 32'(m));
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = '{4'b0001, 25'd1000, 25'd4000, 1'b1, 3'd0, 25'd1000, 25'd4000};
        vt[1] = '{4'b0001, 25'd2000, 25'd4000, 1'b1, 3'd0, 25'd2000, 25'd4000};
        vt[2] = '{4'b0001, 25'd5000, 25'd4000, 1'b1, 3'd0, 25'd4000, 25'd4000};
        vt[3] = '{4'b0001, 25'd50,   25'd100,  1'b1, 3'd0, 25'd0,    25'd128};
        vt[4] = '{4'b0001, 25'd127,  25'd127,  1'b1, 3'd0, 25'd0,    25'd128};
        vt[5] = '{4'b0001, 25'd1000, 25'd4000, 1'b1, 3'd0, 25'd1000, 25'd4000};
        vt[6] = '{4'b0000, 25'd1000, 25'd4000, 1'b1, 3'd0, 25'd4000, 25'd4000};
        vt[7] = '{4'b0000, 25'd7,    25'd9,    1'b1, 3'd0, 25'd4000, 25'd4000};

        step();
        step();
        chk_out("reset", 1'b0, 3'd0, 25'd0, 25'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            src_active = vt[i].act;
            set_src(0, vt[i].c0, vt[i].m0);
            step();
            chk_out($sformatf("vec%0d", i), vt[i].en, vt[i].sel, vt[i].cur, vt[i].mx);
        end

        // hold window: 24 ticks still visible, 25th ends it
        frames(24);
        chk_out("hold24", 1'b1, 3'd0, 25'd4000, 25'd4000);
        frame();
        chk("hold25.enable", 32'(enable), 32'd0);
        chk("hold25.busy", 32'(busy), 32'd0);

        // source 1 sanitising, then reactivation during hold
        src_active = 4'b0010;
        set_src(1, 25'd50, 25'd100);
        step();
        chk_out("s1small", 1'b1, 3'd1, 25'd0, 25'd128);
        set_src(1, 25'd5000, 25'd4000);
        step();
        chk_out("s1clip", 1'b1, 3'd1, 25'd4000, 25'd4000);
        src_active = 4'b0000;
        step();
        chk_out("s1drop", 1'b1, 3'd1, 25'd4000, 25'd4000);
        frames(5);
        chk_out("s1hold5", 1'b1, 3'd1, 25'd4000, 25'd4000);
        src_active = 4'b0010;
        set_src(1, 25'd300, 25'd1000);
        step();
        chk_out("s1react", 1'b1, 3'd1, 25'd300, 25'd1000);

        // reset in the middle of a hold
        src_active = 4'b0000;
        step();
        chk_out("s1drop2", 1'b1, 3'd1, 25'd1000, 25'd1000);
        reset_n = 1'b0;
        step();
        chk_out("midreset", 1'b0, 3'd0, 25'd0, 25'd0);
        reset_n = 1'b1;
        src_active = 4'b1000;
        set_src(3, 25'd10, 25'd2000);
        step();
        chk_out("s3", 1'b1, 3'd3, 25'd10, 25'd2000);

        // dwell rotation between sources 0 and 2
        reset_n = 1'b0;
        src_active = 4'b0000;
        step();
        reset_n = 1'b1;
        set_src(0, 25'd100, 25'd1000);
        set_src(2, 25'd200, 25'd2000);
        src_active = 4'b0001;
        step();
        chk_out("rot.start", 1'b1, 3'd0, 25'd100, 25'd1000);
        src_active = 4'b0101;
        step();
        chk("rot.both.sel", 32'(sel), 32'd0);
        frames(2);
        chk("rot.t2.sel", 32'(sel), 32'd0);
        frame();
        if (ROT) chk_out("rot.t3", 1'b1, 3'd2, 25'd200, 25'd2000);
        else     chk_out("rot.t3", 1'b1, 3'd0, 25'd100, 25'd1000);
        frames(3);
        chk_out("rot.t6", 1'b1, 3'd0, 25'd100, 25'd1000);

        // saturation: alone past the dwell, then a rival appears
        src_active = 4'b0001;
        frames(4);
        chk("sat.alone.sel", 32'(sel), 32'd0);
        src_active = 4'b0101;
        step();
        chk("sat.rival.sel", 32'(sel), ROT ? 32'd2 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
